// File: rtl/ysyx_041461_ifreg_pkg.sv
// Shared definitions for the ysyx_041461 fetch front end.
//   - writeback redirect encodings (NOP / MTVEC / MEPC)
//   - trap codes carried with each fetch slot
//   - fetch FSM state encoding
//   - default reset PC and bubble instruction word
package ysyx_041461_ifreg_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  // Bit positions inside the machine CSRs that gate the timer interrupt.
  localparam int MSTATUS_MIE = 3;
  localparam int MIE_MTIE    = 7;
  localparam int MIP_MTIP    = 7;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    MTVEC = 2'd1,
    MEPC  = 2'd2
  } wb_ctrl_e;

  typedef enum logic [3:0] {
    TRAP_NOP        = 4'd0,
    IF_MISALIGN     = 4'd1,
    TIMER_INTERRUPT = 4'd2
  } trap_e;

  typedef enum logic [1:0] {
    REQ      = 2'd0,
    WAIT     = 2'd1,
    HOLD     = 2'd2,
    TRAPWAIT = 2'd3
  } if_state_e;

endpackage

// File: rtl/ysyx_041461_ifreg_irq_chk.sv
// Fetch-time trap detection.
//   mstatus, mie, mip : machine CSRs from writeback (only MIE/MTIE/MTIP used)
//   pc_low            : low two bits of the current fetch PC
//   trap_hit          : a bubble must be issued instead of a fetch
//   trap_code         : TIMER_INTERRUPT beats IF_MISALIGN; TRAP_NOP otherwise
module ysyx_041461_ifreg_irq_chk
  import ysyx_041461_ifreg_pkg::*;
(
  input  logic [63:0] mstatus,
  input  logic [63:0] mie,
  input  logic [63:0] mip,
  input  logic [1:0]  pc_low,
  output logic        trap_hit,
  output logic [3:0]  trap_code
);

  logic irq;
  logic misalign;

  assign irq      = mstatus[MSTATUS_MIE] & mie[MIE_MTIE] & mip[MIP_MTIP];
  assign misalign = |pc_low;
  assign trap_hit = irq | misalign;

  always_comb begin
    trap_code = TRAP_NOP;
    if (irq)           trap_code = TIMER_INTERRUPT;
    else if (misalign) trap_code = IF_MISALIGN;
  end

  // Remaining CSR bits are irrelevant to fetch.
  logic unused_csr_bits;
  assign unused_csr_bits = ^{mstatus[63:4], mstatus[2:0],
                             mie[63:8], mie[6:0], mip[63:8], mip[6:0]};

endmodule

// File: rtl/ysyx_041461_ifreg.sv
// PC register and instruction-fetch front end of the ysyx_041461 core.
//   clk, rst            : clock, synchronous active-high reset
//   WB_IFreg_*, WB_IF_* : writeback redirect request, trap vector, mepc, CSRs
//   IF_WB_ready         : writeback redirect accepted in this cycle
//   EXE_jump_*          : branch/jump redirect from execute
//   IF_req_* / IF_rsp_* : instruction-memory request / response
//   IF_valid/pc/inst/trap, IF_ID_ready : output slot toward IF/ID
//   dbg_state           : current fetch FSM state
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. IF_req_valid is held only while in REQ; the memory returns
// exactly one IF_rsp_valid pulse per accepted request, at least one cycle
// later. The output slot is held stable until IF_valid & IF_ID_ready.
module ysyx_041461_ifreg
  import ysyx_041461_ifreg_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  WB_IFreg_ctrl,
  input  logic [63:0] WB_IFreg_mtvec,
  input  logic [63:0] WB_IFreg_mepc,
  input  logic [63:0] WB_IF_mstatus,
  input  logic [63:0] WB_IF_mie,
  input  logic [63:0] WB_IF_mip,
  output logic        IF_WB_ready,
  input  logic        EXE_jump_valid,
  input  logic [63:0] EXE_jump_pc,
  output logic        IF_req_valid,
  output logic [63:0] IF_req_addr,
  input  logic        IF_req_ready,
  input  logic        IF_rsp_valid,
  input  logic [31:0] IF_rsp_data,
  output logic        IF_valid,
  output logic [63:0] IF_pc,
  output logic [31:0] IF_inst,
  output logic [3:0]  IF_trap,
  input  logic        IF_ID_ready,
  output logic [1:0]  dbg_state
);

  if_state_e   state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic        slot_valid, slot_valid_nxt;
  logic [31:0] inst, inst_nxt;
  logic [3:0]  trap, trap_nxt;

  logic        trap_hit;
  logic [3:0]  trap_code;
  logic        wb_ready;
  logic        wb_take;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        req_valid;

  ysyx_041461_ifreg_irq_chk u_irq_chk (
    .mstatus   (WB_IF_mstatus),
    .mie       (WB_IF_mie),
    .mip       (WB_IF_mip),
    .pc_low    (pc[1:0]),
    .trap_hit  (trap_hit),
    .trap_code (trap_code)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_nxt;
  end

  // PC and output-slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      drop       <= 1'b0;
      slot_valid <= 1'b0;
      inst       <= '0;
      trap       <= TRAP_NOP;
    end else begin
      pc         <= pc_nxt;
      drop       <= drop_nxt;
      slot_valid <= slot_valid_nxt;
      inst       <= inst_nxt;
      trap       <= trap_nxt;
    end
  end

  // Output / redirect decode. Writeback may only redirect when no live
  // fetch is outstanding; a fetch already marked for dropping is not live.
  always_comb begin
    wb_ready    = (state != WAIT) | drop;
    wb_take     = wb_ready & ((WB_IFreg_ctrl == MTVEC) | (WB_IFreg_ctrl == MEPC));
    redirect    = wb_take | EXE_jump_valid;
    redirect_pc = EXE_jump_pc;
    if (wb_take) begin
      redirect_pc = (WB_IFreg_ctrl == MTVEC) ? {WB_IFreg_mtvec[63:2], 2'b00}
                                             : WB_IFreg_mepc;
    end
    // A redirecting cycle issues nothing, so the old PC never reaches
    // memory and the new target is requested the following cycle.
    req_valid   = ~rst & (state == REQ) & ~trap_hit & ~redirect;
  end

  // Next-state logic.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_nxt       = drop;
    slot_valid_nxt = slot_valid;
    inst_nxt       = inst;
    trap_nxt       = trap;
    if (redirect) begin
      pc_nxt         = redirect_pc;
      slot_valid_nxt = 1'b0;
      // With a response still owed, stay in WAIT and throw it away when it
      // shows up; otherwise start fetching the target right away.
      if ((state == WAIT) && !IF_rsp_valid) begin
        state_nxt = WAIT;
        drop_nxt  = 1'b1;
      end else begin
        state_nxt = REQ;
        drop_nxt  = 1'b0;
      end
    end else begin
      case (state)
        REQ: begin
          if (trap_hit) begin
            slot_valid_nxt = 1'b1;
            inst_nxt       = NOP_INST;
            trap_nxt       = trap_code;
            state_nxt      = HOLD;
          end else if (IF_req_ready) begin
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (IF_rsp_valid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = REQ;
            end else begin
              slot_valid_nxt = 1'b1;
              inst_nxt       = IF_rsp_data;
              trap_nxt       = TRAP_NOP;
              state_nxt      = HOLD;
            end
          end
        end
        HOLD: begin
          if (IF_ID_ready) begin
            slot_valid_nxt = 1'b0;
            if (trap != TRAP_NOP) begin
              state_nxt = TRAPWAIT;
            end else begin
              pc_nxt    = pc + 64'd4;
              state_nxt = REQ;
            end
          end
        end
        TRAPWAIT: begin
          state_nxt = TRAPWAIT;
        end
        default: state_nxt = REQ;
      endcase
    end
  end

  assign IF_WB_ready  = wb_ready;
  assign IF_req_valid = req_valid;
  assign IF_req_addr  = pc;
  assign IF_valid     = slot_valid;
  assign IF_pc        = pc;
  assign IF_inst      = inst;
  assign IF_trap      = trap;
  assign dbg_state    = state;

  // Direct-mode trap vector: the mode bits are not part of the target.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^WB_IFreg_mtvec[1:0];

endmodule

// File: tb/tb_ysyx_041461_ifreg.sv
// Bench for ysyx_041461_ifreg: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_ysyx_041461_ifreg;
  import ysyx_041461_ifreg_pkg::*;

  logic        clk, rst;
  logic [1:0]  WB_IFreg_ctrl;
  logic [63:0] WB_IFreg_mtvec, WB_IFreg_mepc, WB_IF_mstatus, WB_IF_mie, WB_IF_mip;
  logic        IF_WB_ready, EXE_jump_valid;
  logic [63:0] EXE_jump_pc;
  logic        IF_req_valid, IF_req_ready, IF_rsp_valid;
  logic [63:0] IF_req_addr;
  logic [31:0] IF_rsp_data;
  logic        IF_valid, IF_ID_ready;
  logic [63:0] IF_pc;
  logic [31:0] IF_inst;
  logic [3:0]  IF_trap;
  logic [1:0]  dbg_state;

  ysyx_041461_ifreg dut (
    .clk(clk), .rst(rst),
    .WB_IFreg_ctrl(WB_IFreg_ctrl), .WB_IFreg_mtvec(WB_IFreg_mtvec),
    .WB_IFreg_mepc(WB_IFreg_mepc), .WB_IF_mstatus(WB_IF_mstatus),
    .WB_IF_mie(WB_IF_mie), .WB_IF_mip(WB_IF_mip), .IF_WB_ready(IF_WB_ready),
    .EXE_jump_valid(EXE_jump_valid), .EXE_jump_pc(EXE_jump_pc),
    .IF_req_valid(IF_req_valid), .IF_req_addr(IF_req_addr),
    .IF_req_ready(IF_req_ready), .IF_rsp_valid(IF_rsp_valid),
    .IF_rsp_data(IF_rsp_data), .IF_valid(IF_valid), .IF_pc(IF_pc),
    .IF_inst(IF_inst), .IF_trap(IF_trap), .IF_ID_ready(IF_ID_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Fetch front end seen as: an architectural PC, at most one memory
  // request in flight (possibly already abandoned), a one-entry output
  // slot, and a "parked" flag after a trap slot has been handed on.
  logic [63:0] m_pc;
  logic        m_out, m_stale, m_full, m_parked;
  logic [31:0] m_inst;
  logic [3:0]  m_trap;
  bit          m_known;

  // ---------------- memory model ----------------
  int          mem_due[$];
  logic [31:0] exp_q[$];      // words the memory will return, in order
  logic [63:0] req_log[$];
  int          cyc;
  int          lat_min, lat_max;
  bit          force_rsp;
  logic [31:0] stray_word;

  // One clock cycle: present memory response, compare at negedge,
  // advance model at posedge, return 1 time unit after the edge.
  task automatic step();
    bit          pop, irq, idle, trap_now, wb_ok, wb_take, redir, req_exp;
    logic [3:0]  code;
    logic [63:0] tgt;
    pop = 0;
    if (force_rsp) begin
      IF_rsp_valid = 1'b1; IF_rsp_data = stray_word;
    end else if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      IF_rsp_valid = 1'b1; IF_rsp_data = exp_q[0]; pop = 1;
    end else begin
      IF_rsp_valid = 1'b0; IF_rsp_data = $urandom;
    end
    @(negedge clk);
    irq      = WB_IF_mstatus[3] & WB_IF_mie[7] & WB_IF_mip[7];
    idle     = !m_out && !m_full && !m_parked;
    trap_now = idle && (irq || (m_pc[1:0] != 2'b00));
    code     = irq ? TIMER_INTERRUPT : IF_MISALIGN;
    wb_ok    = !(m_out && !m_stale);
    wb_take  = wb_ok && (WB_IFreg_ctrl == MTVEC || WB_IFreg_ctrl == MEPC);
    tgt      = (WB_IFreg_ctrl == MTVEC) ? (WB_IFreg_mtvec & ~64'h3) : WB_IFreg_mepc;
    if (!wb_take) tgt = EXE_jump_pc;
    redir    = wb_take || EXE_jump_valid;
    req_exp  = !rst && idle && !trap_now && !redir;
    if (m_known) begin
      check("req_valid", IF_req_valid, req_exp);
      if (req_exp) check("req_addr", IF_req_addr, m_pc);
      check("wb_ready", IF_WB_ready, wb_ok);
      check("if_valid", IF_valid, m_full);
      check("if_pc", IF_pc, m_pc);
      if (m_full) begin
        check("if_inst", IF_inst, m_inst);
        check("if_trap", IF_trap, m_trap);
      end
    end
    if (IF_req_valid && IF_req_ready && !rst) begin
      req_log.push_back(IF_req_addr);
      mem_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      exp_q.push_back($urandom);
    end
    @(posedge clk);
    if (rst) begin
      m_pc = DEFAULT_RESET_PC; m_out = 0; m_stale = 0; m_full = 0;
      m_parked = 0; m_inst = '0; m_trap = TRAP_NOP; m_known = 1;
    end else if (redir) begin
      m_pc = tgt; m_full = 0; m_parked = 0;
      if (m_out) begin
        if (IF_rsp_valid) begin m_out = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else if (m_out) begin
      if (IF_rsp_valid) begin
        m_out = 0;
        if (m_stale) m_stale = 0;
        else begin m_full = 1; m_inst = IF_rsp_data; m_trap = TRAP_NOP; end
      end
    end else if (m_full) begin
      if (IF_ID_ready) begin
        m_full = 0;
        if (m_trap != TRAP_NOP) m_parked = 1;
        else m_pc = m_pc + 64'd4;
      end
    end else if (!m_parked) begin
      if (trap_now) begin m_full = 1; m_inst = 32'h0000_0013; m_trap = code; end
      else if (IF_req_ready) m_out = 1;
    end
    if (rst) begin
      mem_due.delete(); exp_q.delete();
    end else if (pop) begin
      void'(mem_due.pop_front()); void'(exp_q.pop_front());
    end
    cyc++;
    #1;
  endtask

  task automatic rand_inputs();
    logic [63:0] jpc;
    rst            = ($urandom_range(199, 0) == 0);
    WB_IFreg_ctrl  = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(2, 1)) : 2'd0;
    WB_IFreg_mtvec = {32'h0, 16'h8000, 16'($urandom)};
    WB_IFreg_mepc  = {32'h0, 16'h8000, 16'($urandom)};
    jpc            = {32'h0, 16'h8000, 16'($urandom)};
    if ($urandom_range(3, 0) != 0) jpc[1:0] = 2'b00;
    if ($urandom_range(15, 0) == 0) jpc = 64'hFFFF_FFFF_FFFF_FFF8;
    EXE_jump_pc    = jpc;
    EXE_jump_valid = ($urandom_range(11, 0) == 0);
    WB_IF_mstatus  = {$urandom, $urandom};
    WB_IF_mie      = {$urandom, $urandom};
    WB_IF_mip      = {$urandom, $urandom};
    WB_IF_mip[7]   = ($urandom_range(7, 0) == 0);
    IF_ID_ready    = ($urandom_range(9, 0) < 7);
    IF_req_ready   = ($urandom_range(9, 0) < 7);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          hit;
    logic [63:0] cap_pc;
    logic [31:0] cap_inst;
    rst = 1; WB_IFreg_ctrl = NOP; WB_IFreg_mtvec = '0; WB_IFreg_mepc = '0;
    WB_IF_mstatus = '0; WB_IF_mie = '0; WB_IF_mip = '0;
    EXE_jump_valid = 0; EXE_jump_pc = '0; IF_req_ready = 1; IF_ID_ready = 1;
    IF_rsp_valid = 0; IF_rsp_data = '0;
    lat_min = 1; lat_max = 1; force_rsp = 0; stray_word = 32'hDEAD_BEEF;
    m_known = 0; cyc = 0;
    #1;
    step(); step();
    check("rst_valid", IF_valid, 1'b0);
    check("rst_pc", IF_pc, 64'h8000_0000);
    check("rst_inst", IF_inst, 32'h0);
    check("rst_trap", IF_trap, TRAP_NOP);
    rst = 0; #1;
    check("first_req_valid", IF_req_valid, 1'b1);

    // Sequential fetch, 1-cycle memory.
    for (int i = 0; i < 12; i++) step();
    check("seq_req_count", 64'(req_log.size() >= 3), 1);
    if (req_log.size() >= 3) begin
      check("seq_addr0", req_log[0], 64'h8000_0000);
      check("seq_addr1", req_log[1], 64'h8000_0004);
      check("seq_addr2", req_log[2], 64'h8000_0008);
    end

    // Timer interrupt bubble, then MTVEC redirect.
    WB_IF_mstatus = 64'h8; WB_IF_mie = 64'h80; WB_IF_mip = 64'h80;
    for (int i = 0; i < 20 && !(m_full && m_trap == TIMER_INTERRUPT); i++) step();
    check("irq_valid", IF_valid, 1'b1);
    check("irq_inst", IF_inst, 32'h13);
    check("irq_trap", IF_trap, TIMER_INTERRUPT);
    WB_IF_mip = 64'h0;
    step(); step();
    WB_IFreg_ctrl = MTVEC; WB_IFreg_mtvec = 64'h8000_1003;
    step();
    WB_IFreg_ctrl = NOP; #1;
    check("mtvec_req_valid", IF_req_valid, 1'b1);
    check("mtvec_req_addr", IF_req_addr, 64'h8000_1000);

    // EXE jump while a fetch is outstanding: stale response dropped.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && !(m_out && !m_stale); i++) step();
    EXE_jump_valid = 1; EXE_jump_pc = 64'h8000_0102;
    step();
    EXE_jump_valid = 0; #1;
    check("drop_wb_ready", IF_WB_ready, 1'b1);
    for (int i = 0; i < 10 && !m_full; i++) step();
    check("misalign_trap", IF_trap, IF_MISALIGN);
    check("misalign_pc", IF_pc, 64'h8000_0102);
    hit = 0;
    foreach (req_log[k]) if (req_log[k] == 64'h8000_0102) hit = 1;
    check("misalign_no_req", 64'(hit), 0);
    EXE_jump_valid = 1; EXE_jump_pc = 64'h8000_0200;
    step();
    EXE_jump_valid = 0;

    // MEPC redirect held off by an outstanding fetch.
    IF_ID_ready = 0;
    for (int i = 0; i < 20 && !(m_out && !m_stale); i++) step();
    WB_IFreg_ctrl = MEPC; WB_IFreg_mepc = 64'h8000_0040;
    for (int i = 0; i < 10 && m_pc != 64'h8000_0040; i++) step();
    WB_IFreg_ctrl = NOP; #1;
    check("mepc_flush", IF_valid, 1'b0);
    check("mepc_req_valid", IF_req_valid, 1'b1);
    check("mepc_req_addr", IF_req_addr, 64'h8000_0040);

    // Output stall: slot must stay put, no new request.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && !m_full; i++) step();
    cap_pc = m_pc; cap_inst = m_inst;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", IF_valid, 1'b1);
      check("stall_pc", IF_pc, cap_pc);
      check("stall_inst", IF_inst, cap_inst);
      check("stall_no_req", IF_req_valid, 1'b0);
    end
    IF_ID_ready = 1;

    // Reset while waiting on memory; a late response must be ignored.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && !m_out; i++) step();
    rst = 1;
    step();
    rst = 0; #1;
    check("midrst_valid", IF_valid, 1'b0);
    check("midrst_pc", IF_pc, 64'h8000_0000);
    check("midrst_req_addr", IF_req_addr, 64'h8000_0000);
    check("midrst_req_valid", IF_req_valid, 1'b1);
    force_rsp = 1;
    step();
    force_rsp = 0;
    for (int i = 0; i < 20 && !m_full; i++) step();
    check("midrst_slot_valid", IF_valid, 1'b1);
    check("midrst_slot_pc", IF_pc, 64'h8000_0000);
    check("midrst_not_stray", 64'(IF_inst == stray_word), 0);

    // Randomized traffic.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
